fp_add_normalize_seq: RTL and testbench
=======================================

// Module: fp_add_normalize_seq
// PURPOSE
// Multi-cycle normalize/round back end for FP add/subtract; consumes aligned operands + guard/round/sticky.
// Adds or subtracts, renormalizes via bounded left shifts, rounds to nearest-even, packs IEEE-754 single.
// Sits after the alignment stage on low-area configs; replaces the pipelined normalize/round stages.
// One scalar lane. Valid/ready on both sides; rollback-aware.
// PARAMETERS
// NORM_SHIFT_PER_CYCLE  8  max left-shift bit positions applied per S_NORM cycle (1..27)
// PORTS
// clk                    in   1   clock
// reset                  in   1   synchronous, active-low reset
// in_valid               in   1   operand bundle valid
// in_ready               out  1   block can accept (state == S_IDLE)
// in_thread_idx          in   local_thread_idx_t  issuing thread
// in_significand_le      in   32  larger-exponent significand, hidden bit at [23], [31:24]=0
// in_significand_se      in   32  aligned smaller significand, same format
// in_guard/in_round/in_sticky  in  1 each  bits shifted out during alignment
// in_logical_subtract    in   1   1: le - se, else le + se
// in_exponent            in   8   biased exponent of le
// in_sign                in   1   result sign
// in_result_is_inf/nan   in   1 each  special-case override
// wb_rollback_en         in   1   rollback request
// wb_rollback_thread_idx in   local_thread_idx_t
// wb_rollback_pipeline   in   pipeline_sel_t
// out_valid              out  1   result valid
// out_ready              in   1   consumer accepts
// out_thread_idx         out  local_thread_idx_t
// out_result             out  32  packed IEEE single
// BEHAVIOUR
// - Reset (reset==0 at clk edge): state S_IDLE, out_valid 0, out_result 0, out_thread_idx 0; in_ready 0 while reset low.
// - Accept on in_valid && in_ready; captured thread is "held thread".
// - Internal sum: 28 bits {carry, 24 significand, G, R, S}; operands {le[23:0],3'b0} and {se[23:0],g,r,s}.
// - S_ADD (1 cycle): add/sub. Carry set -> shift right 1, S |= dropped bit, exp+1.
//   Sum zero -> result +0 (sign 0), go S_DONE. Special in -> S_DONE: inf = {sign,8'hFF,23'h0}, nan = 32'h7FFFFFFF.
// - S_NORM: each cycle shift left by min(lzc, NORM_SHIFT_PER_CYCLE, exp-1), exp -= shift.
//   Exit to S_ROUND when hidden bit [26] set or exp == 1 (denormal; packed exponent 0).
//   Skipped entirely if hidden bit already set after S_ADD.
// - S_ROUND (1 cycle): round_up = G & (R | S | LSB). Significand overflow -> exp+1, shift right.
//   exp >= 255 -> inf. Denormal rounding into hidden bit -> exp 1.
// - S_DONE: out_valid=1; out_result/out_thread_idx stable until out_valid && out_ready; then S_IDLE.
// - Latency: accept at T, out_valid at T+3 with no normalization; +ceil(shift/NORM_SHIFT_PER_CYCLE) otherwise.
// - Specials/zero: out_valid at T+2.
// - Rollback: wb_rollback_en && thread == held thread && pipeline == PIPE_MEM in any non-IDLE state.
//   -> S_IDLE next cycle, result dropped; out_valid low the following cycle even if in S_DONE.
//   Same-cycle in_valid from the rolled-back thread is not accepted.
//   Rollback of another thread or another pipeline: no effect.
// - Rollback and out_ready in the same S_DONE cycle: rollback wins; the handshake does not count.
// - Back-to-back: in_ready rises the cycle after the output handshake (no same-cycle bypass).
// STRUCTURE
// - defines package: fp_norm_state_t {S_IDLE, S_ADD, S_NORM, S_ROUND, S_DONE}; FP_QNAN = 32'h7FFFFFFF.
// - Sub-module fp_norm_lzc: combinational 27-bit leading-zero count, 5-bit output.
// - Top: FSM, sum/exponent registers, round logic.
// TESTING
// 1. 1.0+1.0: le=se=0x800000, exp=127, g/r/s=0, add -> out_result 0x40000000, out_valid at T+3.
// 2. Subtract: le=0x800000, se=0x7FFFFF, g=1, exp=127 -> 0x33800000; 3 S_NORM cycles; out_valid at T+6.
// 3. Ties to even: le=0x800000, se=0, g=1, add, exp=127 -> 0x3F800000; le=0x800001 -> 0x3F800002.
// 4. Overflow: le=se=0xFFFFFF, exp=254, add -> 0x7F800000; in_result_is_nan=1 -> 0x7FFFFFFF at T+2.
// 5. Rollback: thread 2 in S_NORM, rollback thread 2 PIPE_MEM -> no out_valid, in_ready=1 next cycle.
//    Same with thread 1 or a non-MEM pipeline -> result delivered normally.
// 6. Backpressure + reset: out_ready low 5 cycles -> result stable, in_ready 0.
//    reset low mid-S_NORM -> out_valid 0, S_IDLE.

Source files
------------

// File: rtl/fp_add_normalize_seq_pkg.sv
// Shared types for the sequential FP add normalize/round back end.
// Thread index, writeback pipeline select and FSM state encoding.
package fp_add_normalize_seq_pkg;

  typedef logic [1:0] local_thread_idx_t;

  typedef enum logic [1:0] {
    PIPE_SCALAR,
    PIPE_MEM,
    PIPE_FP,
    PIPE_VEC
  } pipeline_sel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } fp_norm_state_t;

  localparam logic [31:0] FP_QNAN = 32'h7FFF_FFFF;
  localparam int SUM_W = 28;

endpackage

// File: rtl/fp_add_normalize_seq_lzc.sv
// Leading-zero count of the 27-bit working significand.
// An all-zero input reports 27.
module fp_norm_lzc (
  input  logic [26:0] value,
  output logic [4:0]  count
);

  always_comb begin
    count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (value[i]) count = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp_add_normalize_seq.sv
// Multi-cycle add/normalize/round back end for IEEE single add/sub.
// Bounded left shift per cycle, round-to-nearest-even, rollback aware.
module fp_add_normalize_seq
  import fp_add_normalize_seq_pkg::*;
#(
  parameter int NORM_SHIFT_PER_CYCLE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  local_thread_idx_t in_thread_idx,
  input  logic [31:0]       in_significand_le,
  input  logic [31:0]       in_significand_se,
  input  logic              in_guard,
  input  logic              in_round,
  input  logic              in_sticky,
  input  logic              in_logical_subtract,
  input  logic [7:0]        in_exponent,
  input  logic              in_sign,
  input  logic              in_result_is_inf,
  input  logic              in_result_is_nan,
  input  logic              wb_rollback_en,
  input  local_thread_idx_t wb_rollback_thread_idx,
  input  pipeline_sel_t     wb_rollback_pipeline,
  output logic              out_valid,
  input  logic              out_ready,
  output local_thread_idx_t out_thread_idx,
  output logic [31:0]       out_result
);

  fp_norm_state_t state, state_nxt;

  logic [SUM_W-1:0] op_a, op_b, sum;
  logic [9:0]       exp;
  logic             sub, sign, is_inf, is_nan;

  logic             accept, squash;
  logic             unused_hi;

  logic [SUM_W-1:0] raw, add_sum;
  logic [9:0]       add_exp;
  logic             add_zero, special;

  logic [4:0]       lzc, shamt;
  logic [9:0]       exp_m1, norm_exp;
  logic [SUM_W-1:0] norm_sum;

  logic             round_up;
  logic [24:0]      rnd_sig;
  logic [23:0]      fin_sig;
  logic [9:0]       rnd_exp;
  logic [31:0]      rnd_result;

  assign unused_hi = ^{in_significand_le[31:24], in_significand_se[31:24]};

  assign in_ready  = (state == S_IDLE) && reset;
  assign out_valid = (state == S_DONE);

  // A rollback aimed at the offering thread also vetoes its new issue.
  assign accept = in_valid && in_ready &&
                  !(wb_rollback_en &&
                    wb_rollback_pipeline == PIPE_MEM &&
                    wb_rollback_thread_idx == in_thread_idx);

  assign squash = wb_rollback_en &&
                  wb_rollback_pipeline == PIPE_MEM &&
                  wb_rollback_thread_idx == out_thread_idx &&
                  state != S_IDLE;

  assign raw      = sub ? op_a - op_b : op_a + op_b;
  assign add_sum  = raw[27] ? {1'b0, raw[27:2], raw[1] | raw[0]} : raw;
  assign add_exp  = exp + {9'd0, raw[27]};
  assign add_zero = (raw == '0);
  assign special  = is_inf | is_nan;

  fp_norm_lzc u_lzc (
    .value (sum[26:0]),
    .count (lzc)
  );

  // Never shift the exponent below 1; stop there as a denormal.
  always_comb begin
    exp_m1 = exp - 10'd1;
    shamt  = lzc;
    if (shamt > 5'(NORM_SHIFT_PER_CYCLE)) shamt = 5'(NORM_SHIFT_PER_CYCLE);
    if ({5'd0, shamt} > exp_m1) shamt = exp_m1[4:0];
  end

  assign norm_sum = sum << shamt;
  assign norm_exp = exp - {5'd0, shamt};

  always_comb begin
    round_up = sum[2] & (sum[1] | sum[0] | sum[3]);
    rnd_sig  = {1'b0, sum[26:3]} + {24'd0, round_up};
    fin_sig  = rnd_sig[23:0];
    rnd_exp  = exp;
    if (rnd_sig[24]) begin
      fin_sig = rnd_sig[24:1];
      rnd_exp = exp + 10'd1;
    end
    if (rnd_exp >= 10'd255) begin
      rnd_result = {sign, 8'hFF, 23'd0};
    end else begin
      rnd_result = {sign, fin_sig[23] ? rnd_exp[7:0] : 8'd0, fin_sig[22:0]};
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_ADD;
      S_ADD: begin
        if (special || add_zero) state_nxt = S_DONE;
        else if (add_sum[26] || add_exp <= 10'd1) state_nxt = S_ROUND;
        else state_nxt = S_NORM;
      end
      S_NORM: begin
        if (norm_sum[26] || norm_exp <= 10'd1) state_nxt = S_ROUND;
      end
      S_ROUND: state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (squash) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_a           <= '0;
      op_b           <= '0;
      sum            <= '0;
      exp            <= '0;
      sub            <= 1'b0;
      sign           <= 1'b0;
      is_inf         <= 1'b0;
      is_nan         <= 1'b0;
      out_thread_idx <= '0;
      out_result     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_a           <= {1'b0, in_significand_le[23:0], 3'b000};
            op_b           <= {1'b0, in_significand_se[23:0],
                               in_guard, in_round, in_sticky};
            sub            <= in_logical_subtract;
            exp            <= {2'd0, in_exponent};
            sign           <= in_sign;
            is_inf         <= in_result_is_inf;
            is_nan         <= in_result_is_nan;
            out_thread_idx <= in_thread_idx;
          end
        end
        S_ADD: begin
          sum <= add_sum;
          exp <= add_exp;
          if (is_nan)        out_result <= FP_QNAN;
          else if (is_inf)   out_result <= {sign, 8'hFF, 23'd0};
          else if (add_zero) out_result <= 32'd0;
        end
        S_NORM: begin
          sum <= norm_sum;
          exp <= norm_exp;
        end
        S_ROUND: out_result <= rnd_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_normalize_seq.sv
// Bench for fp_add_normalize_seq: directed cases plus random ops
// against an exact-arithmetic IEEE single reference.
module tb_fp_add_normalize_seq;
  import fp_add_normalize_seq_pkg::*;

  localparam int N = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  local_thread_idx_t in_thread_idx = '0;
  logic [31:0]       in_significand_le = '0;
  logic [31:0]       in_significand_se = '0;
  logic              in_guard = 1'b0;
  logic              in_round = 1'b0;
  logic              in_sticky = 1'b0;
  logic              in_logical_subtract = 1'b0;
  logic [7:0]        in_exponent = '0;
  logic              in_sign = 1'b0;
  logic              in_result_is_inf = 1'b0;
  logic              in_result_is_nan = 1'b0;
  logic              wb_rollback_en = 1'b0;
  local_thread_idx_t wb_rollback_thread_idx = '0;
  pipeline_sel_t     wb_rollback_pipeline = PIPE_SCALAR;
  logic              out_valid;
  logic              out_ready = 1'b1;
  local_thread_idx_t out_thread_idx;
  logic [31:0]       out_result;

  int n_checks = 0;
  int n_fail   = 0;

  fp_add_normalize_seq #(.NORM_SHIFT_PER_CYCLE(N)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .in_thread_idx          (in_thread_idx),
    .in_significand_le      (in_significand_le),
    .in_significand_se      (in_significand_se),
    .in_guard               (in_guard),
    .in_round               (in_round),
    .in_sticky              (in_sticky),
    .in_logical_subtract    (in_logical_subtract),
    .in_exponent            (in_exponent),
    .in_sign                (in_sign),
    .in_result_is_inf       (in_result_is_inf),
    .in_result_is_nan       (in_result_is_nan),
    .wb_rollback_en         (wb_rollback_en),
    .wb_rollback_thread_idx (wb_rollback_thread_idx),
    .wb_rollback_pipeline   (wb_rollback_pipeline),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .out_thread_idx         (out_thread_idx),
    .out_result             (out_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Exact value = (A +/- B) * 2^(e-153); round once, RNE.
  function automatic logic [31:0] ref_fp(
    input logic [23:0] le, input logic [23:0] se, input logic [2:0] grs,
    input logic sub, input int e, input logic sign,
    input logic inf, input logic nan, output int lat);
    longint a, b, m, q, rem, half;
    int p, ex, k, sh;
    a = longint'(le) * 8;
    b = longint'(se) * 8 + longint'(grs);
    lat = 2;
    if (nan) return FP_QNAN;
    if (inf) return {sign, 8'hFF, 23'd0};
    m = sub ? a - b : a + b;
    if (m == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 40; i++) if (m[i]) p = i;
    sh = (p >= 26) ? 0 : (((26 - p) < (e - 1)) ? (26 - p) : (e - 1));
    lat = 3 + (sh + N - 1) / N;
    ex = e + p - 26;
    if (ex < 1) ex = 1;
    k = ex - e + 3;
    if (k <= 0) begin
      q = m << (-k);
    end else begin
      q = m >> k;
      rem = m & ((longint'(1) << k) - 1);
      half = longint'(1) << (k - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end
    if (q >= (longint'(1) << 24)) begin
      q = q >> 1;
      ex++;
    end
    if (ex >= 255) return {sign, 8'hFF, 23'd0};
    return {sign, (q >= 64'h80_0000) ? 8'(ex) : 8'd0, q[22:0]};
  endfunction

  task automatic drive(input logic [23:0] le, input logic [23:0] se,
                       input logic [2:0] grs, input logic sub,
                       input logic [7:0] e, input logic sign,
                       input logic inf, input logic nan,
                       input local_thread_idx_t th);
    in_significand_le   = {8'd0, le};
    in_significand_se   = {8'd0, se};
    {in_guard, in_round, in_sticky} = grs;
    in_logical_subtract = sub;
    in_exponent         = e;
    in_sign             = sign;
    in_result_is_inf    = inf;
    in_result_is_nan    = nan;
    in_thread_idx       = th;
  endtask

  // Returns at the negedge one cycle after acceptance (cycle T+1).
  task automatic issue(input logic [23:0] le, input logic [23:0] se,
                       input logic [2:0] grs, input logic sub,
                       input logic [7:0] e, input logic sign,
                       input logic inf, input logic nan,
                       input local_thread_idx_t th);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("issue_ready", 32'(in_ready), 1);
    drive(le, se, grs, sub, e, sign, inf, nan, th);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int n0,
                             input logic [31:0] want, input int lat,
                             input local_thread_idx_t th);
    int n;
    n = n0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 1);
    check(tag, out_result, want);
    check({tag, "_lat"}, n, lat);
    check({tag, "_thr"}, 32'(out_thread_idx), 32'(th));
  endtask

  task automatic rollback_pulse(input local_thread_idx_t th,
                                input pipeline_sel_t pipe);
    wb_rollback_en         = 1'b1;
    wb_rollback_thread_idx = th;
    wb_rollback_pipeline   = pipe;
    @(negedge clk);
    wb_rollback_en = 1'b0;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    check(tag, hits, 0);
  endtask

  initial begin
    logic [23:0] le, se;
    logic [2:0]  grs;
    logic        sub, sign, inf, nan;
    int          e, lat, mode, sp;
    logic [31:0] want, held;
    local_thread_idx_t th;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_thread", 32'(out_thread_idx), 0);
    reset = 1'b1;

    issue(24'h800000, 24'h800000, 3'b000, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0, 2'd1);
    wait_result("one_plus_one", 1, 32'h4000_0000, 3, 2'd1);

    issue(24'h800000, 24'h7FFFFF, 3'b100, 1'b1, 8'd127, 1'b0, 1'b0, 1'b0, 2'd3);
    wait_result("sub_cancel", 1, 32'h3380_0000, 6, 2'd3);

    issue(24'h800000, 24'h000000, 3'b100, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0, 2'd0);
    wait_result("tie_even_down", 1, 32'h3F80_0000, 3, 2'd0);

    issue(24'h800001, 24'h000000, 3'b100, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0, 2'd0);
    wait_result("tie_even_up", 1, 32'h3F80_0002, 3, 2'd0);

    issue(24'hFFFFFF, 24'hFFFFFF, 3'b000, 1'b0, 8'd254, 1'b0, 1'b0, 1'b0, 2'd2);
    wait_result("overflow_inf", 1, 32'h7F80_0000, 3, 2'd2);

    issue(24'hFFFFFF, 24'hFFFFFF, 3'b000, 1'b0, 8'd254, 1'b0, 1'b0, 1'b1, 2'd2);
    wait_result("nan_override", 1, 32'h7FFF_FFFF, 2, 2'd2);

    issue(24'h800000, 24'h000000, 3'b000, 1'b0, 8'd10, 1'b1, 1'b1, 1'b0, 2'd1);
    wait_result("inf_override", 1, 32'hFF80_0000, 2, 2'd1);

    issue(24'hABCDEF, 24'hABCDEF, 3'b000, 1'b1, 8'd77, 1'b1, 1'b0, 1'b0, 2'd1);
    wait_result("exact_zero", 1, 32'h0000_0000, 2, 2'd1);

    // Denormal: shift clamped at exponent 1.
    want = ref_fp(24'h800000, 24'h7FFFFF, 3'b100, 1'b1, 10, 1'b0, 1'b0, 1'b0, lat);
    issue(24'h800000, 24'h7FFFFF, 3'b100, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 2'd1);
    wait_result("denormal", 1, want, lat, 2'd1);

    // Rollback of the held thread while normalizing.
    issue(24'h800000, 24'h7FFFFF, 3'b100, 1'b1, 8'd127, 1'b0, 1'b0, 1'b0, 2'd2);
    @(negedge clk);
    rollback_pulse(2'd2, PIPE_MEM);
    check("rb_hit_out_valid", 32'(out_valid), 0);
    check("rb_hit_in_ready", 32'(in_ready), 1);
    expect_quiet("rb_hit_quiet", 10);

    issue(24'h800000, 24'h7FFFFF, 3'b100, 1'b1, 8'd127, 1'b0, 1'b0, 1'b0, 2'd2);
    @(negedge clk);
    rollback_pulse(2'd1, PIPE_MEM);
    wait_result("rb_other_thread", 3, 32'h3380_0000, 6, 2'd2);

    issue(24'h800000, 24'h7FFFFF, 3'b100, 1'b1, 8'd127, 1'b0, 1'b0, 1'b0, 2'd2);
    @(negedge clk);
    rollback_pulse(2'd2, PIPE_FP);
    wait_result("rb_other_pipe", 3, 32'h3380_0000, 6, 2'd2);

    // Rollback wins over a same-cycle output handshake.
    issue(24'h800000, 24'h800000, 3'b000, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0, 2'd2);
    wait_result("rb_done_pre", 1, 32'h4000_0000, 3, 2'd2);
    rollback_pulse(2'd2, PIPE_MEM);
    check("rb_done_out_valid", 32'(out_valid), 0);
    check("rb_done_in_ready", 32'(in_ready), 1);

    // Issue from the thread being rolled back is refused.
    @(negedge clk);
    drive(24'h800000, 24'h800000, 3'b000, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0, 2'd3);
    in_valid = 1'b1;
    rollback_pulse(2'd3, PIPE_MEM);
    in_valid = 1'b0;
    check("rb_issue_refused", 32'(in_ready), 1);
    expect_quiet("rb_issue_quiet", 6);

    // Backpressure holds the result.
    out_ready = 1'b0;
    issue(24'h800000, 24'h800000, 3'b000, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0, 2'd1);
    wait_result("bp_first", 1, 32'h4000_0000, 3, 2'd1);
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_stable", out_result, held);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 0);
    check("bp_release_ready", 32'(in_ready), 1);

    // Reset in the middle of normalization.
    issue(24'h800000, 24'h7FFFFF, 3'b100, 1'b1, 8'd127, 1'b0, 1'b0, 1'b0, 2'd2);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_ready", 32'(in_ready), 0);
    check("mid_rst_result", out_result, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 1);
    expect_quiet("post_rst_quiet", 6);

    for (int it = 0; it < 150; it++) begin
      le   = 24'h800000 | 24'($urandom_range(0, 32'h7FFFFF));
      sub  = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        se  = le - 24'($urandom_range(0, 300));
        grs = 3'b000;
      end else begin
        se  = 24'($urandom()) >> $urandom_range(1, 24);
        grs = 3'($urandom_range(0, 7));
      end
      e    = (mode == 1) ? $urandom_range(1, 30) : $urandom_range(1, 254);
      sign = 1'($urandom_range(0, 1));
      sp   = $urandom_range(0, 19);
      inf  = (sp == 0);
      nan  = (sp == 1);
      th   = 2'($urandom_range(0, 3));
      want = ref_fp(le, se, grs, sub, e, sign, inf, nan, lat);
      issue(le, se, grs, sub, 8'(e), sign, inf, nan, th);
      wait_result("rand", 1, want, lat, th);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
